// File: rtl/phy_rx_pkg.sv
// Shared constants, status codes and state encodings for the 802.11b DSSS receive path.
package phy_rx_pkg;

  // SIGNAL field values, units of 100 kb/s
  localparam logic [7:0]  RATE_1M     = 8'h0A;
  localparam logic [7:0]  RATE_2M     = 8'h14;
  localparam logic [7:0]  RATE_5M5    = 8'h37;
  localparam logic [7:0]  RATE_11M    = 8'h6E;

  localparam logic [15:0] MAX_LEN_US  = 16'd20000;
  localparam logic [15:0] HDR_TIMEOUT = 16'd400;

  typedef enum logic [2:0] {
    RX_OK       = 3'd0,
    RX_HDR_CRC  = 3'd1,
    RX_BAD_RATE = 3'd2,
    RX_BAD_LEN  = 3'd3,
    RX_TIMEOUT  = 3'd4,
    RX_ABORT    = 3'd5
  } rx_status_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SEARCH   = 3'd1,
    S_WAIT_HDR = 3'd2,
    S_PSDU     = 3'd3,
    S_END      = 3'd4
  } rx_state_e;

  // Header validation in priority order; only 1 Mbps frames of whole bytes are accepted.
  function automatic rx_status_e hdr_check(input logic crc_ok, input logic [7:0] rate,
                                           input logic [15:0] len);
    if (!crc_ok)
      return RX_HDR_CRC;
    if (rate != RATE_1M)
      return RX_BAD_RATE;
    if (len == 16'd0 || len[2:0] != 3'd0 || len > MAX_LEN_US)
      return RX_BAD_LEN;
    return RX_OK;
  endfunction

endpackage

// File: rtl/rx_frame_sequencer_if.sv
// Bundle between the PHY front end, the MAC and rx_frame_sequencer.
interface rx_frame_sequencer_if;
  import phy_rx_pkg::*;

  // No ready/back-pressure anywhere: data_valid, pkt_header_valid_strobe and every output
  // pulse are single-cycle qualifiers; their data fields are only meaningful while the
  // qualifier is high (rx_status and frame_len_bytes hold their last value between events).
  logic        rx_enable;
  logic        data_bit;
  logic        data_valid;
  logic        preamble_detected;
  logic        pkt_header_valid_strobe;
  logic        pkt_header_valid;
  logic [7:0]  pkt_rate;
  logic [15:0] pkt_len;

  logic        hdr_search_en;
  logic        detector_restart;
  logic        rx_busy;
  logic        rx_start;
  logic        rx_end;
  logic [2:0]  rx_status;
  logic [12:0] frame_len_bytes;
  logic [7:0]  psdu_byte;
  logic        psdu_byte_valid;
  rx_state_e   state;

  modport master (
    input  rx_enable, data_bit, data_valid, preamble_detected,
           pkt_header_valid_strobe, pkt_header_valid, pkt_rate, pkt_len,
    output hdr_search_en, detector_restart, rx_busy, rx_start, rx_end, rx_status,
           frame_len_bytes, psdu_byte, psdu_byte_valid, state
  );

  modport slave (
    output rx_enable, data_bit, data_valid, preamble_detected,
           pkt_header_valid_strobe, pkt_header_valid, pkt_rate, pkt_len,
    input  hdr_search_en, detector_restart, rx_busy, rx_start, rx_end, rx_status,
           frame_len_bytes, psdu_byte, psdu_byte_valid, state
  );

endinterface

// File: rtl/psdu_byte_packer.sv
// Serial-to-byte packer: bits arrive LSB first, a byte pulse follows the 8th bit by one cycle.
module psdu_byte_packer (
  input  logic       clk,
  input  logic       reset,
  input  logic       data_bit,
  input  logic       bit_valid,
  input  logic       flush,
  output logic [7:0] data_byte,
  output logic       byte_valid
);

  logic [7:0] shreg;
  logic [2:0] cnt;

  // flush dominates: a partial byte is dropped and a completing bit is not reported
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg      <= 8'd0;
      cnt        <= 3'd0;
      data_byte  <= 8'd0;
      byte_valid <= 1'b0;
    end else if (flush) begin
      shreg      <= 8'd0;
      cnt        <= 3'd0;
      byte_valid <= 1'b0;
    end else if (bit_valid) begin
      shreg      <= {data_bit, shreg[7:1]};
      cnt        <= cnt + 3'd1;
      byte_valid <= (cnt == 3'd7);
      if (cnt == 3'd7)
        data_byte <= {data_bit, shreg[7:1]};
    end else begin
      byte_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rx_frame_sequencer.sv
// Receive frame controller: header search, header validation, PSDU byte gating and MAC status.
module rx_frame_sequencer
  import phy_rx_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  rx_frame_sequencer_if.master bus
);

  rx_state_e  state, nxt_state;
  rx_status_e nxt_status, hdr_status, status_q;
  logic       accept;
  logic [15:0] bit_cnt;
  logic [12:0] len_bytes_q;
  logic       busy_q, start_q, restart_q;
  logic       in_psdu, pk_valid, pk_flush;
  logic       enter_end;

  assign hdr_status = hdr_check(bus.pkt_header_valid, bus.pkt_rate, bus.pkt_len);
  assign enter_end  = (state != S_END) && (nxt_state == S_END);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt_state;
  end

  // Strobe is tested before the timeout so a header landing on the last allowed bit wins.
  always_comb begin
    nxt_state  = state;
    nxt_status = RX_OK;
    accept     = 1'b0;
    unique case (state)
      S_IDLE:
        if (bus.rx_enable) nxt_state = S_SEARCH;
      S_SEARCH:
        if (!bus.rx_enable)             nxt_state = S_IDLE;
        else if (bus.preamble_detected) nxt_state = S_WAIT_HDR;
      S_WAIT_HDR:
        if (!bus.rx_enable) begin
          nxt_state = S_IDLE;
        end else if (bus.pkt_header_valid_strobe) begin
          nxt_status = hdr_status;
          accept     = (hdr_status == RX_OK);
          nxt_state  = accept ? S_PSDU : S_END;
        end else if (bus.data_valid && bit_cnt >= HDR_TIMEOUT - 16'd1) begin
          nxt_status = RX_TIMEOUT;
          nxt_state  = S_END;
        end
      S_PSDU:
        if (!bus.rx_enable) begin
          nxt_status = RX_ABORT;
          nxt_state  = S_END;
        end else if (bus.data_valid && bit_cnt <= 16'd1) begin
          nxt_status = RX_OK;
          nxt_state  = S_END;
        end
      S_END:
        nxt_state = bus.rx_enable ? S_SEARCH : S_IDLE;
      default:
        nxt_state = S_IDLE;
    endcase
  end

  always_comb begin
    bus.hdr_search_en = (state == S_SEARCH) || (state == S_WAIT_HDR);
    bus.rx_end        = (state == S_END);
    bus.state         = state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt     <= 16'd0;
      len_bytes_q <= 13'd0;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      restart_q   <= 1'b0;
      status_q    <= RX_OK;
    end else begin
      start_q   <= accept;
      restart_q <= ((state == S_IDLE) && bus.rx_enable) || enter_end;
      if (accept)
        busy_q <= 1'b1;
      else if (state == S_END)
        busy_q <= 1'b0;
      if (enter_end)
        status_q <= nxt_status;
      if (accept)
        len_bytes_q <= bus.pkt_len[15:3];
      // bit_cnt counts up while waiting for a header and down through the PSDU
      unique case (state)
        S_SEARCH:
          if (bus.preamble_detected) bit_cnt <= 16'd0;
        S_WAIT_HDR:
          if (accept)
            bit_cnt <= bus.data_valid ? bus.pkt_len - 16'd1 : bus.pkt_len;
          else if (bus.data_valid)
            bit_cnt <= bit_cnt + 16'd1;
        S_PSDU:
          if (bus.data_valid && bus.rx_enable && bit_cnt != 16'd0)
            bit_cnt <= bit_cnt - 16'd1;
        default: ;
      endcase
    end
  end

  assign bus.rx_start         = start_q;
  assign bus.rx_busy          = busy_q;
  assign bus.detector_restart = restart_q;
  assign bus.rx_status        = status_q;
  assign bus.frame_len_bytes  = len_bytes_q;

  // The accepting cycle already belongs to the PSDU, so its data bit is bit 0.
  assign in_psdu  = bus.rx_enable && ((state == S_PSDU) || accept);
  assign pk_valid = in_psdu && bus.data_valid;
  assign pk_flush = !in_psdu;

  psdu_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .data_bit   (bus.data_bit),
    .bit_valid  (pk_valid),
    .flush      (pk_flush),
    .data_byte  (bus.psdu_byte),
    .byte_valid (bus.psdu_byte_valid)
  );

endmodule
